disp_scan_hex: RTL and testbench
================================

DISP_SCAN_HEX -- requirements
Module: disp_scan_hex

Interface
REQ-001 Parameter: SCAN_CNT, default 50000, clocks per digit slot (legal range 2..2^20).
REQ-002 Parameter: LZB, default 0, leading-zero blanking enable (1 = on).
REQ-003 Port: clk  input  1  system clock, all logic on posedge.
REQ-004 Port: rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Port: hexs  input  16  value to display, typically the 16-bit count of the up/down counter stage; digit k = hexs[4k+3:4k].
REQ-006 Port: points  input  4  decimal point per digit, 1 = lit.
REQ-007 Port: LEs  input  4  per-digit blank, 1 = digit dark.
REQ-008 Port: hold  input  1  1 = freeze snapshot, display keeps last captured frame.
REQ-009 Port: AN  output  4  digit anodes, active-low, one-hot-low or all-high.
REQ-010 Port: SEGMENT  output  8  active-low segments, [7]=dp, [6:0]=g..a.
REQ-011 Port: frame_done  output  1  one-cycle pulse at each frame start.

Function
REQ-012 Prescaler SHALL count 0..SCAN_CNT-1 and wrap; tick = (prescaler == SCAN_CNT-1).
REQ-013 Digit index SHALL be 2 bits, advance only on tick, 3 wraps to 0; after reset the first tick selects digit 0.
REQ-014 Snapshot registers (hexs, points, LEs) SHALL load from inputs on a tick whose next digit is 0 and hold==0; otherwise retain.
REQ-015 On the snapshot-load edge, AN/SEGMENT for digit 0 SHALL use the newly loaded input values (no one-frame lag).
REQ-016 AN and SEGMENT SHALL be registered and change only on tick edges; between ticks they are stable.
REQ-017 On tick, AN SHALL drive low only the bit of the next digit, unless that digit is blanked, then AN=4'b1111 and SEGMENT=8'hFF.
REQ-018 Hex encoding (SEGMENT[6:0], dp off gives bit7=1): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
REQ-019 points[k]=1 SHALL clear SEGMENT[7] while digit k is shown, independent of encoding.
REQ-020 Digit k blanked if LEs[k]=1, or if LZB=1, k>0, and nibbles k..3 of snapshot are all zero; digit 0 never blanked by LZB.
REQ-021 frame_done SHALL pulse high for exactly the clock after the edge that selects digit 0, regardless of hold.
REQ-022 Input changes mid-frame SHALL not affect displayed digits until next frame start.
REQ-023 Frame period SHALL be exactly 4*SCAN_CNT clocks.

Reset
REQ-024 rst=1 at a clock edge SHALL set prescaler=0, digit index=3 (so the next tick selects 0), snapshot=0, AN=4'b1111, SEGMENT=8'hFF, frame_done=0.
REQ-025 rst SHALL override tick, hold and all inputs; asserted mid-frame it aborts the frame with no pulse on frame_done.
REQ-026 After rst deasserts, first tick SHALL occur SCAN_CNT clocks later.

Verification (SCAN_CNT=4)
REQ-027 Reset, hexs=16'h1234, points=0, LEs=0 -> AN=1111 for 4 clocks, then AN sequence 1110/1101/1011/0111 each held 4 clocks, SEGMENT 99,B0,A4,F9; frame_done pulses every 16 clocks.
REQ-028 hexs changes 16'h1234->16'hABCD while digit 1 shown -> digits 2,3 still show 2,1; next frame shows D,C,B,A (A1,C6,83,88).
REQ-029 hold=1 across frame boundary with hexs changed -> old digits repeat; frame_done still pulses; hold=0 -> new value at next frame.
REQ-030 LZB=1, hexs=16'h0000 -> only digit 0 lit (C0), other slots AN=1111; hexs=16'h00F0 -> digits 0,1 lit (C0,8E), 2,3 dark.
REQ-031 points=4'b0100, LEs=4'b0001, hexs=16'h8888 -> digit 2 SEGMENT=00, digit 0 slot AN=1111/SEGMENT=FF, others 80.
REQ-032 rst pulsed while digit 2 shown -> next edge AN=1111, SEGMENT=FF, no frame_done; restart timing per REQ-026.

Source files
------------

// File: rtl/disp_scan_hex.sv
// Four-digit multiplexed hex display scanner with a per-frame input snapshot,
// per-digit decimal points and blanking, optional leading-zero blanking, and a frame pulse.
module disp_scan_hex #(
    parameter int SCAN_CNT = 50000,
    parameter int LZB      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  LEs,
    input  logic        hold,
    output logic [3:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam int             PW      = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam logic [PW-1:0]  PRE_MAX = PW'(SCAN_CNT - 1);

    // Active-low g..a pattern for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit;
    logic [15:0]   r_hex;
    logic [3:0]    r_pts;
    logic [3:0]    r_les;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;
    logic          r_frame;

    logic          w_tick;
    logic [1:0]    w_next_digit;
    logic          w_frame_start;
    logic          w_load;
    logic [15:0]   w_hex;
    logic [3:0]    w_pts;
    logic [3:0]    w_les;
    logic [3:0]    w_nib;
    logic          w_upper_zero;
    logic          w_blank;
    logic [3:0]    w_an_next;
    logic [7:0]    w_seg_next;

    // Next-digit decode; on the frame-start tick the fresh inputs bypass the snapshot
    always_comb begin
        w_tick        = (r_presc == PRE_MAX);
        w_next_digit  = r_digit + 2'd1;
        w_frame_start = w_tick && (w_next_digit == 2'd0);
        w_load        = w_frame_start && !hold;
        w_hex         = w_load ? hexs   : r_hex;
        w_pts         = w_load ? points : r_pts;
        w_les         = w_load ? LEs    : r_les;
        w_nib         = 4'h0;
        w_upper_zero  = 1'b0;
        case (w_next_digit)
            2'd0: begin
                w_nib        = w_hex[3:0];
                w_upper_zero = 1'b0;
            end
            2'd1: begin
                w_nib        = w_hex[7:4];
                w_upper_zero = (w_hex[15:4] == 12'h000);
            end
            2'd2: begin
                w_nib        = w_hex[11:8];
                w_upper_zero = (w_hex[15:8] == 8'h00);
            end
            2'd3: begin
                w_nib        = w_hex[15:12];
                w_upper_zero = (w_hex[15:12] == 4'h0);
            end
            default: begin
                w_nib        = 4'h0;
                w_upper_zero = 1'b0;
            end
        endcase
        w_blank = w_les[w_next_digit] || ((LZB != 0) && w_upper_zero);
        if (w_blank) begin
            w_an_next  = 4'hF;
            w_seg_next = 8'hFF;
        end else begin
            w_an_next  = ~(4'b0001 << w_next_digit);
            w_seg_next = {~w_pts[w_next_digit], hex_to_seg(w_nib)};
        end
    end

    // Prescaler, digit scan, snapshot and registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_digit <= 2'd3;
            r_hex   <= 16'h0000;
            r_pts   <= 4'h0;
            r_les   <= 4'h0;
            r_an    <= 4'hF;
            r_seg   <= 8'hFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_frame_start;
            if (w_tick) begin
                r_presc <= '0;
                r_digit <= w_next_digit;
                r_an    <= w_an_next;
                r_seg   <= w_seg_next;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            if (w_load) begin
                r_hex <= hexs;
                r_pts <= points;
                r_les <= LEs;
            end
        end
    end

    assign AN         = r_an;
    assign SEGMENT    = r_seg;
    assign frame_done = r_frame;

endmodule

// File: tb/tb_disp_scan_hex.sv
// Directed bench for disp_scan_hex at SCAN_CNT=4: one instance without and one with
// leading-zero blanking, driven from shared stimulus.
module tb_disp_scan_hex;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hexs;
    logic [3:0]  points;
    logic [3:0]  LEs;
    logic        hold;
    logic [3:0]  an0, an1;
    logic [7:0]  seg0, seg1;
    logic        fd0, fd1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    disp_scan_hex #(.SCAN_CNT(4), .LZB(0)) u_dut (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs), .hold(hold),
        .AN(an0), .SEGMENT(seg0), .frame_done(fd0)
    );

    disp_scan_hex #(.SCAN_CNT(4), .LZB(1)) u_lzb (
        .clk(clk), .rst(rst), .hexs(hexs), .points(points), .LEs(LEs), .hold(hold),
        .AN(an1), .SEGMENT(seg1), .frame_done(fd1)
    );

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [3:0] an, input logic [7:0] seg, input logic fd);
        chk({tag, ".AN"}, {4'h0, an0}, {4'h0, an});
        chk({tag, ".SEG"}, seg0, seg);
        chk({tag, ".FD"}, {7'h00, fd0}, {7'h00, fd});
    endtask

    task automatic chk_lzb(input string tag, input logic [3:0] an, input logic [7:0] seg);
        chk({tag, ".LZB_AN"}, {4'h0, an1}, {4'h0, an});
        chk({tag, ".LZB_SEG"}, seg1, seg);
    endtask

    initial begin
        rst = 1'b1; hexs = 16'h1234; points = 4'h0; LEs = 4'h0; hold = 1'b0;
        go(1);                                   // E0 reset edge
        rst = 1'b0;
        chk_main("reset", 4'hF, 8'hFF, 1'b0);
        chk_lzb("reset", 4'hF, 8'hFF);
        go(3);                                   // E3 no tick yet
        chk_main("pre_tick", 4'hF, 8'hFF, 1'b0);
        go(1);                                   // E4 digit 0
        chk_main("f1_d0", 4'hE, 8'h99, 1'b1);
        go(1);
        chk_main("f1_d0_hold", 4'hE, 8'h99, 1'b0);
        go(3);                                   // E8 digit 1
        chk_main("f1_d1", 4'hD, 8'hB0, 1'b0);
        hexs = 16'hABCD;                         // mid-frame change
        go(4);
        chk_main("f1_d2_old", 4'hB, 8'hA4, 1'b0);
        go(4);
        chk_main("f1_d3_old", 4'h7, 8'hF9, 1'b0);
        go(4);                                   // E20 new frame
        chk_main("f2_d0", 4'hE, 8'hA1, 1'b1);
        go(4);
        chk_main("f2_d1", 4'hD, 8'hC6, 1'b0);
        go(4);
        chk_main("f2_d2", 4'hB, 8'h83, 1'b0);
        go(4);                                   // E32
        chk_main("f2_d3", 4'h7, 8'h88, 1'b0);
        hold = 1'b1; hexs = 16'h1234;
        go(4);                                   // E36 frame start under hold
        chk_main("hold_d0", 4'hE, 8'hA1, 1'b1);
        hold = 1'b0;
        go(4);
        chk_main("hold_d1", 4'hD, 8'hC6, 1'b0);
        go(8);                                   // E48
        chk_main("hold_d3", 4'h7, 8'h88, 1'b0);
        go(4);                                   // E52 released snapshot
        chk_main("rel_d0", 4'hE, 8'h99, 1'b1);
        points = 4'b0100; LEs = 4'b0001; hexs = 16'h8888;
        go(4);
        chk_main("pts_old_d1", 4'hD, 8'hB0, 1'b0);
        go(12);                                  // E68 digit 0 blanked
        chk_main("le_d0", 4'hF, 8'hFF, 1'b1);
        go(4);
        chk_main("le_d1", 4'hD, 8'h80, 1'b0);
        go(4);
        chk_main("pt_d2", 4'hB, 8'h00, 1'b0);
        go(4);                                   // E80
        chk_main("le_d3", 4'h7, 8'h80, 1'b0);
        points = 4'h0; LEs = 4'h0; hexs = 16'h0000;
        go(4);                                   // E84
        chk_main("z_d0", 4'hE, 8'hC0, 1'b1);
        chk_lzb("z_d0", 4'hE, 8'hC0);
        hexs = 16'h00F0;
        go(4);
        chk_main("z_d1", 4'hD, 8'hC0, 1'b0);
        chk_lzb("z_d1", 4'hF, 8'hFF);
        go(4);
        chk_lzb("z_d2", 4'hF, 8'hFF);
        go(4);
        chk_lzb("z_d3", 4'hF, 8'hFF);
        go(4);                                   // E100
        chk_lzb("f0_d0", 4'hE, 8'hC0);
        go(4);
        chk_lzb("f0_d1", 4'hD, 8'h8E);
        go(4);                                   // E108 digit 2 shown
        chk_lzb("f0_d2", 4'hF, 8'hFF);
        chk_main("f0_d2", 4'hB, 8'hC0, 1'b0);
        rst = 1'b1;
        go(1);                                   // E109 mid-frame reset
        rst = 1'b0;
        chk_main("midrst", 4'hF, 8'hFF, 1'b0);
        go(3);                                   // E112 would have been a tick
        chk_main("midrst_wait", 4'hF, 8'hFF, 1'b0);
        go(1);                                   // E113 first tick after reset
        chk_main("restart_d0", 4'hE, 8'hC0, 1'b1);
        chk_lzb("restart_d0", 4'hE, 8'hC0);
        go(4);
        chk_lzb("restart_d1", 4'hD, 8'h8E);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
